weight_dump: RTL
================

// Module: weight_dump
// PURPOSE
//  Framed UART transmitter: the PC-bound counterpart of the weight loader. On a start pulse,
//  reads LENGTH bytes from a synchronous-read byte memory (weight BRAM read port) and sends
//  0xAA 0x55, the data bytes (raw, unescaped), then 0x55 0xAA at 8N1. Used for readback/verification.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock in Hz
//  BAUD_RATE  115200       line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (868 at defaults)
//  ADDR_W     14           memory address width (16 KB)
// PORTS
//  clk       in   1       system clock; single clock domain
//  rst_n     in   1       asynchronous, active-low reset
//  start     in   1       1-cycle request; accepted only when busy=0
//  length    in   ADDR_W  number of data bytes to send; latched on the accepted start
//  mem_addr  out  ADDR_W  read address to BRAM
//  mem_data  in   8       BRAM read data, valid 1 cycle after mem_addr
//  tx        out  1       UART TX line, idle high
//  busy      out  1       high from the cycle after start is accepted until done
//  done      out  1       1-cycle pulse after the final stop bit of 0xAA trailer
// BEHAVIOUR
//  Reset (async assert, sync release): tx=1, busy=0, done=0, mem_addr=0, FSM=IDLE, uart_tx idle.
//  Reset mid-frame: tx forced high immediately, no partial byte resumes, no done pulse.
//  FSM: IDLE -> HDR1(0xAA) -> HDR2(0x55) -> [FETCH -> WAIT_RD -> SEND] x length -> TRL1(0x55)
//   -> TRL2(0xAA) -> DONE -> IDLE.
//  IDLE: start=1 latches length into remaining count, clears mem_addr, sets busy next cycle.
//  HDR/TRL/SEND states: assert tx_start for 1 cycle with the byte, then wait for tx_done.
//  FETCH drives mem_addr; WAIT_RD waits exactly 1 cycle; SEND captures mem_data, increments
//   mem_addr, decrements count. When count==0 after HDR2 (or after a SEND), go to TRL1.
//  length==0: header+trailer only (4 bytes on the line).
//  mem_addr never wraps: max length 2**ADDR_W-1; addresses 0..length-1 sent in order.
//  start while busy=1: ignored, no effect on the current frame or on latched length.
//  DONE: done=1 for exactly 1 cycle, busy=0 in the same cycle; start in that cycle ignored,
//   start accepted from the next cycle (back-to-back frames allowed).
//  Byte timing: 10 bits (start=0, 8 data LSB first, stop=1), each held CLKS_PER_BIT cycles;
//   inter-byte gap <= 3 clk cycles. Frame time ~ (length+4)*10*CLKS_PER_BIT cycles.
//  Data is not escaped: a 0x55 0xAA pair inside the data terminates the loader's frame early;
//   that is a protocol property, not a fault of this block.
// STRUCTURE
//  Shared package/header: START_BYTE1=0xAA, START_BYTE2=0x55, END_BYTE1=0x55, END_BYTE2=0xAA,
//   CLKS_PER_BIT derivation; the loader uses the same constants.
//  One sub-module: uart_tx (CLK_FREQ, BAUD_RATE; ports clk, rst_n, data[7:0], start, tx,
//   busy, done). 8N1, bit counter + 14-bit baud counter; done pulses at end of stop bit.
//  weight_dump holds the frame FSM, byte counter, address counter, and byte mux.
// TESTING (sim with BAUD_RATE set so CLKS_PER_BIT=8; UART monitor decodes tx)
//  1 length=0, start -> line bytes AA 55 55 AA; done pulse once; busy low after.
//  2 mem[0..2]=01,02,03, length=3 -> AA 55 01 02 03 55 AA; mem_addr seen 0,1,2 only.
//  3 start re-pulsed at mid-frame with length=9 -> ignored; frame of test 2 unchanged.
//  4 rst_n low mid-data-byte -> tx=1 same cycle (async), busy=0, no done; new start works.
//  5 start in cycle after done -> second frame starts, no idle glitch (tx stays 1 between).
//  6 loopback: tx -> weight_load rx, 200 random bytes without 55 AA pair -> loader
//    transfer_done=1 and BRAM contents match source.

Source files
------------

// File: rtl/weight_dump_pkg.sv
// Shared framing constants for the weight loader / weight dump pair.
// The baud divider derivation is here as well, so both ends compute it the same way.
package weight_dump_pkg;

    localparam logic [7:0] START_BYTE1 = 8'hAA;
    localparam logic [7:0] START_BYTE2 = 8'h55;
    localparam logic [7:0] END_BYTE1   = 8'h55;
    localparam logic [7:0] END_BYTE2   = 8'hAA;

    localparam int BAUD_CNT_W = 14;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/weight_dump_if.sv
// Control, memory-read and line signals of the weight dump.
// The slave side is the dump itself; the master side is the host/memory environment.
interface weight_dump_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [ADDR_W-1:0] length;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (output start, length, mem_data, input mem_addr, tx, busy, done);
    modport slave  (input start, length, mem_data, output mem_addr, tx, busy, done);
endinterface

// File: rtl/weight_dump_uart_tx.sv
// 8N1 UART transmitter. The data byte is latched on start; done is asserted
// combinationally in the last cycle of the stop bit, so the next byte can follow with minimal gap.
module uart_tx
    import weight_dump_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int                    CPB      = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [BAUD_CNT_W-1:0] CPB_LAST = BAUD_CNT_W'(CPB - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic                  bit_end;

    assign bit_end = (baud_cnt == CPB_LAST);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (start) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: if (bit_end) begin
                    // shreg[0] always holds the next bit to put on the line
                    tx      <= shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= '0;
                    state   <= S_DATA;
                end
                S_DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: if (bit_end) state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/weight_dump.sv
// Frame FSM: sends AA 55, LENGTH bytes read from a sync-read BRAM, then 55 AA.
// Data bytes are sent raw; escaping is left to the protocol user.
module weight_dump
    import weight_dump_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int ADDR_W    = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    weight_dump_if.slave   bus
);
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_HDR1  = 4'd1;
    localparam logic [3:0] ST_HDR2  = 4'd2;
    localparam logic [3:0] ST_FETCH = 4'd3;
    localparam logic [3:0] ST_WAIT  = 4'd4;
    localparam logic [3:0] ST_SEND  = 4'd5;
    localparam logic [3:0] ST_TRL1  = 4'd6;
    localparam logic [3:0] ST_TRL2  = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    logic [3:0]        state;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] addr;
    logic              sent;
    logic              is_tx;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic              tx_done;
    logic              byte_done;

    assign is_tx     = (state == ST_HDR1) || (state == ST_HDR2) || (state == ST_SEND) ||
                       (state == ST_TRL1) || (state == ST_TRL2);
    assign tx_start  = is_tx && !sent && !tx_busy;
    assign byte_done = sent && tx_done;

    always_comb begin
        tx_byte = bus.mem_data;
        case (state)
            ST_HDR1: tx_byte = START_BYTE1;
            ST_HDR2: tx_byte = START_BYTE2;
            ST_TRL1: tx_byte = END_BYTE1;
            ST_TRL2: tx_byte = END_BYTE2;
            default: tx_byte = bus.mem_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            addr  <= '0;
            sent  <= 1'b0;
        end else begin
            if (tx_start)      sent <= 1'b1;
            else if (tx_done)  sent <= 1'b0;

            case (state)
                ST_IDLE: if (bus.start) begin
                    count <= bus.length;
                    addr  <= '0;
                    state <= ST_HDR1;
                end
                ST_HDR1: if (byte_done) state <= ST_HDR2;
                ST_HDR2: if (byte_done) state <= (count == '0) ? ST_TRL1 : ST_FETCH;
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT:  state <= ST_SEND;
                ST_SEND: begin
                    // uart_tx latches mem_data on tx_start; the address stops at the last byte
                    if (tx_start) begin
                        count <= count - 1'b1;
                        if (count != ADDR_W'(1)) addr <= addr + 1'b1;
                    end
                    if (byte_done) state <= (count == '0) ? ST_TRL1 : ST_FETCH;
                end
                ST_TRL1: if (byte_done) state <= ST_TRL2;
                ST_TRL2: if (byte_done) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_addr = addr;
    assign bus.busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign bus.done     = (state == ST_DONE);

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tx_byte),
        .start (tx_start),
        .tx    (bus.tx),
        .busy  (tx_busy),
        .done  (tx_done)
    );

endmodule
